// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: fetch-stage bus between the PC/IF-ID logic, hazard unit, EX and program memory
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Stall_i;
  logic                  Redirect_i;
  logic [DATA_WIDTH-1:0] Redirect_Target_i;
  logic [DATA_WIDTH-1:0] Instruction_i;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [DATA_WIDTH-1:0] Instruction_ID_o;
  logic [DATA_WIDTH-1:0] PC_ID_o;
  logic [DATA_WIDTH-1:0] PC_Plus_4_ID_o;
  logic                  Valid_ID_o;
  logic                  Fetch_Fault_o;
  logic [DATA_WIDTH-1:0] Fault_PC_o;
  modport master (
    input  Stall_i, Redirect_i, Redirect_Target_i, Instruction_i,
    output PC_o, Instruction_ID_o, PC_ID_o, PC_Plus_4_ID_o, Valid_ID_o, Fetch_Fault_o, Fault_PC_o
  );
  modport slave (
    output Stall_i, Redirect_i, Redirect_Target_i, Instruction_i,
    input  PC_o, Instruction_ID_o, PC_ID_o, PC_Plus_4_ID_o, Valid_ID_o, Fetch_Fault_o, Fault_PC_o
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID register with stall, redirect flush and sticky fetch fault
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;
  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(MEMORY_DEPTH * 4);
  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] pc, pc4, instr_id, pc_id, pc4_id, fault_pc;
  logic                  valid_id, fault, tgt_bad, seq_bad;
  assign pc4 = pc + DATA_WIDTH'(4);
  // Offsets below the base wrap to huge values, so one unsigned compare covers both ends of the window
  assign tgt_bad = (bus.Redirect_Target_i[1:0] != 2'b00) || (bus.Redirect_Target_i - RESET_VECTOR >= SPAN);
  assign seq_bad = pc4 - RESET_VECTOR >= SPAN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      instr_id <= NOP_INSTR;
      pc_id    <= '0;
      pc4_id   <= '0;
      valid_id <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.Redirect_i) begin
            instr_id <= NOP_INSTR;
            pc_id    <= '0;
            pc4_id   <= '0;
            valid_id <= 1'b0;
            if (tgt_bad) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= bus.Redirect_Target_i;
            end else begin
              pc <= bus.Redirect_Target_i;
            end
          end else if (!bus.Stall_i) begin
            instr_id <= bus.Instruction_i;
            pc_id    <= pc;
            pc4_id   <= pc4;
            valid_id <= 1'b1;
            if (seq_bad) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= pc4;
            end else begin
              pc <= pc4;
            end
          end
        end
        default: begin
          instr_id <= NOP_INSTR;
          pc_id    <= '0;
          pc4_id   <= '0;
          valid_id <= 1'b0;
        end
      endcase
    end
  end
  assign bus.PC_o             = pc;
  assign bus.Instruction_ID_o = instr_id;
  assign bus.PC_ID_o          = pc_id;
  assign bus.PC_Plus_4_ID_o   = pc4_id;
  assign bus.Valid_ID_o       = valid_id;
  assign bus.Fetch_Fault_o    = fault;
  assign bus.Fault_PC_o       = fault_pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus random stimulus checked against a cycle-level fetch model
module tb_instruction_fetch_unit;
  localparam logic [31:0] RV  = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] mem [32];
  int errors = 0;
  int checks = 0;
  int cnt31 = 0;
  logic [31:0] m_pc, m_ins, m_pcid, m_pc4;
  logic        m_v, m_f, m_boot;
  logic [31:0] m_fpc;
  instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();
  instruction_fetch_unit #(
    .DATA_WIDTH(32), .MEMORY_DEPTH(32), .RESET_VECTOR(RV), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic in_window(input logic [31:0] a);
    return a >= RV && a < RV + 32'd128 && a[1:0] == 2'b00;
  endfunction
  function automatic logic [31:0] fetch(input logic [31:0] a);
    return in_window(a) ? mem[(a - RV) / 4] : 32'hDEAD_BEEF;
  endfunction
  assign bus.Instruction_i = fetch(bus.PC_o);
  task automatic bubble();
    m_ins = NOP; m_pcid = 0; m_pc4 = 0; m_v = 0;
  endtask
  task automatic model(input logic r, input logic s, input logic d, input logic [31:0] t);
    if (r) begin
      m_pc = RV; bubble(); m_f = 0; m_fpc = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_f) begin
      bubble();
    end else if (d) begin
      bubble();
      if (!in_window(t)) begin m_f = 1; m_fpc = t; end
      else m_pc = t;
    end else if (!s) begin
      m_ins = fetch(m_pc); m_pcid = m_pc; m_pc4 = m_pc + 4; m_v = 1;
      if (m_pc + 32'd4 >= RV + 32'd128 || m_pc + 32'd4 < RV) begin m_f = 1; m_fpc = m_pc + 4; end
      else m_pc = m_pc + 4;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("pc", bus.PC_o, m_pc);
    chk("instr_id", bus.Instruction_ID_o, m_ins);
    chk("pc_id", bus.PC_ID_o, m_pcid);
    chk("pc4_id", bus.PC_Plus_4_ID_o, m_pc4);
    chk("valid_id", {31'b0, bus.Valid_ID_o}, {31'b0, m_v});
    chk("fault", {31'b0, bus.Fetch_Fault_o}, {31'b0, m_f});
    chk("fault_pc", bus.Fault_PC_o, m_fpc);
  endtask
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    reset = r; bus.Stall_i = s; bus.Redirect_i = d; bus.Redirect_Target_i = t;
    model(r, s, d, t);
    @(posedge clk);
    #1;
    if (bus.Valid_ID_o && bus.PC_ID_o == RV + 32'h7C) cnt31++;
    check_all();
  endtask
  initial begin
    mem[0] = 32'h0050_0293; mem[1] = 32'h00A0_0313; mem[2] = 32'h0062_83B3; mem[3] = 32'h0000_0013;
    for (int i = 4; i < 32; i++) mem[i] = $urandom;
    bus.Stall_i = 0; bus.Redirect_i = 0; bus.Redirect_Target_i = 0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h0040_0010);
    chk("reset_pc", bus.PC_o, RV);
    step(0, 0, 0, 0);
    chk("boot_no_valid", {31'b0, bus.Valid_ID_o}, 32'd0);
    step(0, 0, 0, 0);
    chk("first_valid_pc", bus.PC_ID_o, RV);
    chk("first_valid_instr", bus.Instruction_ID_o, 32'h0050_0293);
    step(0, 0, 0, 0);
    chk("pc_at_8", bus.PC_o, RV + 32'h8);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("stall_pc_id", bus.PC_ID_o, RV + 32'h4);
    step(0, 0, 0, 0);
    chk("resume_pc_id", bus.PC_ID_o, RV + 32'h8);
    chk("resume_instr", bus.Instruction_ID_o, 32'h0062_83B3);
    step(0, 1, 1, RV + 32'h40);
    chk("redir_pc", bus.PC_o, RV + 32'h40);
    chk("redir_bubble", bus.Instruction_ID_o, NOP);
    step(0, 0, 0, 0);
    chk("redir_word16", bus.Instruction_ID_o, mem[16]);
    step(0, 0, 1, RV + 32'h42);
    chk("mis_fault", {31'b0, bus.Fetch_Fault_o}, 32'd1);
    chk("mis_fault_pc", bus.Fault_PC_o, RV + 32'h42);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, RV + 32'h10);
    chk("fault_sticky_pc", bus.PC_o, RV + 32'h44);
    step(1, 0, 0, 0);
    cnt31 = 0;
    for (int i = 0; i < 40 && !bus.Fetch_Fault_o; i++) step(0, 0, 0, 0);
    chk("oor_fault", {31'b0, bus.Fetch_Fault_o}, 32'd1);
    chk("oor_fault_pc", bus.Fault_PC_o, RV + 32'h80);
    chk("word31_valid", bus.Instruction_ID_o, mem[31]);
    step(0, 0, 0, 0);
    chk("word31_once", cnt31, 32'd1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h003F_FFFC);
    chk("below_fault_pc", bus.Fault_PC_o, 32'h003F_FFFC);
    step(1, 1, 1, RV + 32'h20);
    chk("reset_mid_fault", {31'b0, bus.Fetch_Fault_o}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 9) < 8) ? RV + ($urandom_range(0, 31) << 2) : $urandom;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the RISC-V core: owns the program counter, drives the address of `Program_Memory`, and captures the returned instruction into the IF/ID pipeline register. It handles stalls from the hazard unit, redirects (taken branch/jump) from EX with IF/ID flush, and halts with a sticky fault on a misaligned or out-of-range fetch address. `Program_Memory` is combinational, so the instruction for `PC_o` is available in the same cycle and is registered at the next rising edge.

## Interface
- `DATA_WIDTH`, 32, width of PC and instruction.
- `MEMORY_DEPTH`, 32, words in `Program_Memory`; valid text window is `MEMORY_DEPTH*4` bytes.
- `RESET_VECTOR`, 32'h0040_0000, PC after reset; base of the text window.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `Stall_i` in 1: hold PC and IF/ID.
- `Redirect_i` in 1: taken branch/jump resolved in EX.
- `Redirect_Target_i` in 32: byte address of the redirect.
- `Instruction_i` in 32: from `Program_Memory.Instruction_o`.
- `PC_o` out 32: to `Program_Memory.Address_i`; equals the PC register.
- `Instruction_ID_o` out 32: IF/ID instruction.
- `PC_ID_o` out 32: IF/ID PC of that instruction.
- `PC_Plus_4_ID_o` out 32: IF/ID PC+4, for JAL/JALR link.
- `Valid_ID_o` out 1: IF/ID holds a real instruction.
- `Fetch_Fault_o` out 1: sticky fault flag.
- `Fault_PC_o` out 32: offending address.

## Operation
- Range check `oor(a)`: `(a - RESET_VECTOR) >= MEMORY_DEPTH*4` (32-bit unsigned, so addresses below the base wrap and fail). Misaligned `mis(a)`: `a[1:0] != 0`.
- Bubble: `Instruction_ID_o=NOP_INSTR`, `PC_ID_o=0`, `PC_Plus_4_ID_o=0`, `Valid_ID_o=0`.
- Priority: `reset` > FAULT hold > `Redirect_i` > `Stall_i` > sequential fetch.
- States: BOOT, RUN, FAULT.
- **BOOT**: entered on `reset`. PC=`RESET_VECTOR`, IF/ID=bubble, fault flag 0, `Fault_PC_o`=0. The next cycle always goes to RUN and ignores all inputs.
- **RUN, redirect**:
  - If `mis` or `oor` of the target: go to FAULT, `Fault_PC_o`<=target, PC unchanged, IF/ID<=bubble.
  - Otherwise: PC<=target, IF/ID<=bubble (flush), stay in RUN.
  - A redirect overrides `Stall_i`.
- **RUN, stall** (no redirect): PC and IF/ID hold.
- **RUN, fetch**: IF/ID<={`Instruction_i`, PC, PC+4, valid 1}.
  - If `oor(PC+4)`: go to FAULT, `Fault_PC_o`<=PC+4, PC held. The last instruction is still delivered.
  - Otherwise: PC<=PC+4.
- **FAULT**: `Fetch_Fault_o`=1, PC and `Fault_PC_o` hold. IF/ID<=bubble on every edge, so the delivered last instruction leaves after one cycle. `Stall_i`/`Redirect_i` are ignored. Only `reset` exits.
- PC+4 arithmetic is 32-bit modulo. Wrap past 32'hFFFF_FFFF is caught by `oor`.

## Timing
- Reset values: `PC_o`=`RESET_VECTOR`, IF/ID=bubble, `Fetch_Fault_o`=0, `Fault_PC_o`=0. These values appear on the edge where `reset`=1 is sampled.
- `reset` asserted mid-operation or while in FAULT takes effect at that edge regardless of other inputs.
- After reset deasserts: BOOT takes 1 cycle, then the first fetch edge. The first valid IF/ID (PC=`RESET_VECTOR`) appears 2 edges after `reset` drops.
- Fetch latency: the instruction at `PC_o` during cycle n is on IF/ID outputs after edge n+1.
- Redirect: the target is on `PC_o` the cycle after `Redirect_i`. Its instruction is valid in IF/ID one edge later. Exactly one bubble is inserted per redirect.
- `Fetch_Fault_o` rises on the edge that detects the fault and stays high until `reset`.
- Outputs are registered, except `PC_o`, which is a direct register output with no combinational path from inputs.

## Test plan
- Reset then free run, memory words 0..3 = 0x00500293, 0x00A00313, 0x006283B3, 0x00000013 -> IF/ID shows PC 0x00400000..0x0040000C in order, `Valid_ID_o`=1 from the 2nd edge after reset, `PC_Plus_4_ID_o`=PC+4.
- `Stall_i`=1 for 3 cycles at PC 0x00400008 -> `PC_o` and IF/ID frozen for 3 cycles, then resume at 0x0040000C with no instruction lost or duplicated.
- Redirect to 0x00400040 while `Stall_i`=1 -> next cycle `PC_o`=0x00400040, IF/ID bubble (`Valid_ID_o`=0, instr 0x00000013), then word 16 valid.
- Redirect to 0x00400042 -> `Fetch_Fault_o`=1, `Fault_PC_o`=0x00400042, `PC_o` unchanged, IF/ID bubble. Subsequent stall/redirect ignored until `reset`.
- Sequential run to 0x0040007C (`MEMORY_DEPTH`=32) -> word 31 delivered valid once, then FAULT with `Fault_PC_o`=0x00400080.
- Redirect to 0x003FFFFC (below base) -> FAULT with `Fault_PC_o`=0x003FFFFC. Assert `reset` mid-FAULT -> all outputs return to reset values on that edge.
